// File: rtl/stack_addr_generator.sv
`default_nettype none
// ============================================================================
// Module   : stack_addr_generator
// Purpose  : Address/strobe generator for the stack region (224..255) of the
//            256-byte unified memory. Serves 1..4 byte push/pop requests,
//            one memory beat per cycle, and tracks SP plus full/empty and
//            sticky overflow/underflow status. Address 223 is a guard byte
//            and is never issued.
// Ports    : clk, rst          - clock (rising edge), async active-high reset
//            req_valid/ready   - request handshake (ready only while idle)
//            req_push, req_len - direction and byte count minus one
//            mem_valid/we/re   - memory beat strobes
//            mem_addr,beat_idx - beat address and 0-based beat number
//            done, done_err    - completion pulse and reject qualifier
//            sp                - stack pointer (next free byte)
//            stack_empty/full  - decoded from sp
//            ovf_err, unf_err  - sticky errors, cleared by err_clr
// Revision : 1.0 - initial release
// ============================================================================
module stack_addr_generator #(
  parameter int STACK_TOP    = 255,
  parameter int STACK_BOTTOM = 224,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_push,
  input  logic [1:0]        req_len,
  output logic              mem_valid,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        beat_idx,
  output logic              done,
  output logic              done_err,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              ovf_err,
  output logic              unf_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PUSH   = 2'd1,
    S_POP    = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  // Capacity math is carried one bit wider than the address so that
  // free/used can never wrap around.
  localparam logic [ADDR_W:0]   c_top_ext    = (ADDR_W+1)'(STACK_TOP);
  localparam logic [ADDR_W:0]   c_bottom_ext = (ADDR_W+1)'(STACK_BOTTOM);
  localparam logic [ADDR_W-1:0] c_top        = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] c_full_sp    = ADDR_W'(STACK_BOTTOM - 1);
  localparam logic [ADDR_W-1:0] c_one        = ADDR_W'(1);

  state_t          r_state;
  logic            r_push;
  logic [1:0]      r_last;    // index of the final beat (= req_len)

  logic [ADDR_W:0] w_sp_ext;
  logic [ADDR_W:0] w_free;
  logic [ADDR_W:0] w_used;
  logic [ADDR_W:0] w_n;
  logic            w_accept;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign w_sp_ext  = {1'b0, sp};
  assign w_free    = w_sp_ext - c_bottom_ext + (ADDR_W+1)'(1);
  assign w_used    = c_top_ext - w_sp_ext;
  assign w_n       = (ADDR_W+1)'(req_len) + (ADDR_W+1)'(1);
  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_push_ok = (w_n <= w_free);
  assign w_pop_ok  = (w_n <= w_used);

  assign req_ready   = (r_state == S_IDLE);
  assign stack_empty = (sp == c_top);
  assign stack_full  = (sp == c_full_sp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_push    <= 1'b0;
      r_last    <= 2'd0;
      sp        <= c_top;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= c_top;
      beat_idx  <= 2'd0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      // Clear first; the REJECT branch below sets afterwards, so a set in
      // the same cycle as err_clr takes priority.
      if (err_clr) begin
        ovf_err <= 1'b0;
        unf_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          done     <= 1'b0;
          done_err <= 1'b0;
          if (w_accept) begin
            r_push   <= req_push;
            r_last   <= req_len;
            beat_idx <= 2'd0;
            // The first beat is presented in the cycle right after accept.
            if (req_push && w_push_ok) begin
              r_state   <= S_PUSH;
              mem_valid <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= sp;
              done      <= (req_len == 2'd0);
            end else if (!req_push && w_pop_ok) begin
              r_state   <= S_POP;
              mem_valid <= 1'b1;
              mem_re    <= 1'b1;
              mem_addr  <= sp + c_one;
              done      <= (req_len == 2'd0);
            end else begin
              r_state  <= S_REJECT;
              done     <= 1'b1;
              done_err <= 1'b1;
            end
          end
        end

        S_PUSH: begin
          sp <= sp - c_one;
          if (beat_idx == r_last) begin
            r_state   <= S_IDLE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            beat_idx  <= 2'd0;
            done      <= 1'b0;
          end else begin
            mem_addr <= mem_addr - c_one;
            beat_idx <= beat_idx + 2'd1;
            done     <= (2'(beat_idx + 2'd1) == r_last);
          end
        end

        S_POP: begin
          sp <= sp + c_one;
          if (beat_idx == r_last) begin
            r_state   <= S_IDLE;
            mem_valid <= 1'b0;
            mem_re    <= 1'b0;
            beat_idx  <= 2'd0;
            done      <= 1'b0;
          end else begin
            mem_addr <= mem_addr + c_one;
            beat_idx <= beat_idx + 2'd1;
            done     <= (2'(beat_idx + 2'd1) == r_last);
          end
        end

        S_REJECT: begin
          r_state  <= S_IDLE;
          done     <= 1'b0;
          done_err <= 1'b0;
          if (r_push) ovf_err <= 1'b1;
          else        unf_err <= 1'b1;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_addr_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_addr_generator
// Purpose  : Self-checking bench for stack_addr_generator. A directed table
//            walks the stack through fill/drain boundaries, hand-written
//            sequences cover error clearing and mid-burst reset, and a random
//            phase is checked against a byte-count model of the stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_addr_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_push;
  logic [1:0] req_len;
  logic       mem_valid, mem_we, mem_re;
  logic [7:0] mem_addr;
  logic [1:0] beat_idx;
  logic       done, done_err;
  logic [7:0] sp;
  logic       stack_empty, stack_full;
  logic       ovf_err, unf_err;
  logic       err_clr;

  stack_addr_generator #(
    .STACK_TOP   (255),
    .STACK_BOTTOM(224),
    .ADDR_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_push   (req_push),
    .req_len    (req_len),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .beat_idx   (beat_idx),
    .done       (done),
    .done_err   (done_err),
    .sp         (sp),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the stack is just a count of bytes held, expressed as
  // the next-free address, plus the two sticky flags.
  int sp_m;
  bit ovf_m, unf_m;

  typedef struct {
    bit         push;
    logic [1:0] len;
    bit         ok;
    int         sp_after;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_valid"}, mem_valid, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_sp"}, sp, sp_m);
    chk({tag, "_empty"}, stack_empty, (sp_m == 255));
    chk({tag, "_full"}, stack_full, (sp_m == 223));
    chk({tag, "_ovf"}, ovf_err, ovf_m);
    chk({tag, "_unf"}, unf_err, unf_m);
  endtask

  // Issue one request from IDLE and check every cycle until back in IDLE.
  // rej_seen reports whether the DUT signalled a reject.
  task automatic do_req(input bit push, input logic [1:0] len,
                        input bit clr_in_reject, output bit rej_seen);
    int n, free_b, used_b, addr;
    bit ok;
    n      = int'(len) + 1;
    free_b = sp_m - 224 + 1;
    used_b = 255 - sp_m;
    ok     = push ? (n <= free_b) : (n <= used_b);

    req_valid = 1'b1;
    req_push  = push;
    req_len   = len;
    err_clr   = 1'b0;
    chk("ready_before_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_push  = 1'($urandom);
    req_len   = 2'($urandom);
    rej_seen  = done && done_err;

    if (ok) begin
      for (int b = 0; b < n; b++) begin
        addr = push ? (sp_m - b) : (sp_m + 1 + b);
        chk("beat_valid", mem_valid, 1);
        chk("beat_we", mem_we, push);
        chk("beat_re", mem_re, !push);
        chk("beat_addr", mem_addr, addr);
        chk("beat_idx", beat_idx, b);
        chk("beat_done", done, (b == n - 1));
        chk("beat_done_err", done_err, 0);
        chk("beat_ready", req_ready, 0);
        tick();
      end
      sp_m = push ? (sp_m - n) : (sp_m + n);
      chk("after_done", done, 0);
    end else begin
      chk("rej_done", done, 1);
      chk("rej_done_err", done_err, 1);
      chk("rej_valid", mem_valid, 0);
      chk("rej_ready", req_ready, 0);
      chk("rej_sp", sp, sp_m);
      err_clr = clr_in_reject;
      tick();
      err_clr = 1'b0;
      if (clr_in_reject) begin
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end
      if (push) ovf_m = 1'b1;
      else      unf_m = 1'b1;
      chk("rej_after_done", done, 0);
    end
    chk_status("post");
  endtask

  initial begin
    bit rej;

    tbl[0]  = '{1'b1, 2'd0, 1'b1, 254};
    tbl[1]  = '{1'b1, 2'd3, 1'b1, 250};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 252};
    tbl[3]  = '{1'b0, 2'd3, 1'b0, 252};  // 4-byte pop with only 3 bytes held
    tbl[4]  = '{1'b1, 2'd3, 1'b1, 248};
    tbl[5]  = '{1'b1, 2'd3, 1'b1, 244};
    tbl[6]  = '{1'b1, 2'd3, 1'b1, 240};
    tbl[7]  = '{1'b1, 2'd3, 1'b1, 236};
    tbl[8]  = '{1'b1, 2'd3, 1'b1, 232};
    tbl[9]  = '{1'b1, 2'd3, 1'b1, 228};
    tbl[10] = '{1'b1, 2'd1, 1'b1, 226};
    tbl[11] = '{1'b1, 2'd2, 1'b1, 223};  // exact fill
    tbl[12] = '{1'b1, 2'd0, 1'b0, 223};  // push into a full stack

    rst       = 1'b1;
    req_valid = 1'b0;
    req_push  = 1'b0;
    req_len   = 2'd0;
    err_clr   = 1'b0;
    sp_m      = 255;
    ovf_m     = 1'b0;
    unf_m     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", mem_addr, 255);
    chk("rst_beat_idx", beat_idx, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_done", done, 0);
    chk("rst_done_err", done_err, 0);
    chk_status("rst");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_req(tbl[i].push, tbl[i].len, 1'b0, rej);
      chk("tbl_accepted", !rej, tbl[i].ok);
      chk("tbl_sp", sp, tbl[i].sp_after);
    end

    // err_clr pulse clears both sticky flags
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ovf_m = 1'b0;
    unf_m = 1'b0;
    chk_status("clr");

    // err_clr in the same cycle as a reject: the set wins
    do_req(1'b1, 2'd0, 1'b1, rej);
    chk("clr_vs_set_ovf", ovf_err, 1);

    // Make room, then reset during the second beat of a 4-byte push
    do_req(1'b0, 2'd3, 1'b0, rej);
    req_valid = 1'b1;
    req_push  = 1'b1;
    req_len   = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_burst_valid", mem_valid, 1);
    chk("mid_burst_idx", beat_idx, 1);
    #2;
    rst = 1'b1;
    #1;
    sp_m  = 255;
    ovf_m = 1'b0;
    unf_m = 1'b0;
    chk("arst_we", mem_we, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", mem_addr, 255);
    chk_status("arst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_req(1'b1, 2'd0, 1'b0, rej);

    // Random phase against the model
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        req_valid = 1'b0;
        req_push  = 1'($urandom);
        req_len   = 2'($urandom);
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        chk_status("rnd_clr");
      end else if (r == 1) begin
        req_valid = 1'b0;
        req_push  = 1'($urandom);
        req_len   = 2'($urandom);
        tick();
        chk_status("rnd_idle");
      end else begin
        do_req(1'($urandom), 2'($urandom), 1'($urandom), rej);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
